// File: rtl/diag_rot_pkg.sv
// ---------------------------------------------------------------------------
// diag_rot_pkg
// Shared definitions for the diagonal block rotation engine:
//   - state codes for the engine FSM (IDLE, KEY, LOAD, ROT, WRITE, DONE)
//   - coord_t, a (row, col) pair naming the source pixel of a permutation
//   - rot_fwd / rot_inv : source coordinate of out[r][c] for the forward
//     permutation P and its inverse, with the column-mirrored variant
//     selected by d (d=1 gives M*P*M or M*P^-1*M)
//   - pix_addr : linear SRAM pixel address of a pixel inside a block
// Optional build macro used by the engine: DIAGROT_BLKCNT_EN
// ---------------------------------------------------------------------------
package diag_rot_pkg;

  // FSM state codes, kept as plain constants so older tools and the
  // scrambler's legacy state decode can share them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_KEY   = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_ROT   = 3'd3;
  localparam state_t ST_WRITE = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] c;
  } coord_t;

  // Source of out[r][c] for the plain diagonal shift P.  The interior moves
  // one step down-right; the pixels pushed off the bottom row and right
  // column wrap round into row 0 / column 0.  in[0][n-1] is the fixed point.
  function automatic coord_t p_src(input int r, input int c, input int n);
    coord_t s;
    if (r >= 1 && c >= 1) begin
      s.r = 16'(r - 1);
      s.c = 16'(c - 1);
    end else if (r == 0 && c <= n - 2) begin
      s.r = 16'(n - 1 - c);
      s.c = 16'(n - 1);
    end else if (c == 0) begin
      s.r = 16'(n - 1);
      s.c = 16'(n - 1 - r);
    end else begin
      s.r = 16'd0;
      s.c = 16'(n - 1);
    end
    return s;
  endfunction

  // Source of out[r][c] for P^-1 (the shift undone: up-left with wrap).
  function automatic coord_t p_inv_src(input int r, input int c, input int n);
    coord_t s;
    if (r <= n - 2 && c <= n - 2) begin
      s.r = 16'(r + 1);
      s.c = 16'(c + 1);
    end else if (c == n - 1 && r >= 1) begin
      s.r = 16'd0;
      s.c = 16'(n - 1 - r);
    end else if (r == n - 1 && c <= n - 2) begin
      s.r = 16'(n - 1 - c);
      s.c = 16'd0;
    end else begin
      s.r = 16'd0;
      s.c = 16'(n - 1);
    end
    return s;
  endfunction

  // Mirroring the columns on both sides of P only flips column indices, so
  // the mirrored variant looks up P at the mirrored output column and
  // mirrors the source column it returns.
  function automatic coord_t rot_fwd(input int r, input int c, input int n, input logic d);
    coord_t s;
    s = p_src(r, d ? (n - 1 - c) : c, n);
    if (d) s.c = 16'(n - 1 - int'(s.c));
    return s;
  endfunction

  function automatic coord_t rot_inv(input int r, input int c, input int n, input logic d);
    coord_t s;
    s = p_inv_src(r, d ? (n - 1 - c) : c, n);
    if (d) s.c = 16'(n - 1 - int'(s.c));
    return s;
  endfunction

  // Linear address of pixel (y, x) of block (bx, by) in a raster frame.
  function automatic logic [31:0] pix_addr(input int unsigned bx, input int unsigned by,
                                           input int unsigned y, input int unsigned x,
                                           input int unsigned blk, input int unsigned img_w);
    return 32'((by * blk + y) * img_w + bx * blk + x);
  endfunction

endpackage

// File: rtl/diag_block_buf.sv
// ---------------------------------------------------------------------------
// diag_block_buf
// BLK x BLK pixel buffer for one block.
// Ports:
//   clk                      clock
//   load_en, load_x, load_y,
//   load_data                write port, used while the block is read in
//   rd_x, rd_y, rd_data      asynchronous read port, used for write-back
//   rot_en                   one-cycle strobe: permute the whole buffer
//   dir                      0 = plain diagonal shift, 1 = column-mirrored
//   inv                      1 = apply the inverse permutation
// The buffer has no reset; its contents are always fully overwritten by a
// block load before they are used.
// ---------------------------------------------------------------------------
module diag_block_buf
  import diag_rot_pkg::*;
#(
  parameter  int BLK   = 32,
  parameter  int PIX_W = 16,
  localparam int IW    = $clog2(BLK)
) (
  input  logic             clk,
  input  logic             load_en,
  input  logic [IW-1:0]    load_x,
  input  logic [IW-1:0]    load_y,
  input  logic [PIX_W-1:0] load_data,
  input  logic [IW-1:0]    rd_x,
  input  logic [IW-1:0]    rd_y,
  output logic [PIX_W-1:0] rd_data,
  input  logic             rot_en,
  input  logic             dir,
  input  logic             inv
);

  logic [PIX_W-1:0] mem     [BLK][BLK];
  logic [PIX_W-1:0] rot_val [BLK][BLK];

  // Every destination pixel picks one of four fixed source pixels; the
  // source coordinates are elaboration-time constants, so the rotation is
  // pure wiring plus a 4:1 mux per pixel.
  for (genvar r = 0; r < BLK; r++) begin : g_row
    for (genvar c = 0; c < BLK; c++) begin : g_col
      localparam coord_t F0 = rot_fwd(r, c, BLK, 1'b0);
      localparam coord_t F1 = rot_fwd(r, c, BLK, 1'b1);
      localparam coord_t I0 = rot_inv(r, c, BLK, 1'b0);
      localparam coord_t I1 = rot_inv(r, c, BLK, 1'b1);
      assign rot_val[r][c] =
        inv ? (dir ? mem[I1.r[IW-1:0]][I1.c[IW-1:0]] : mem[I0.r[IW-1:0]][I0.c[IW-1:0]])
            : (dir ? mem[F1.r[IW-1:0]][F1.c[IW-1:0]] : mem[F0.r[IW-1:0]][F0.c[IW-1:0]]);
    end
  end

  // Storage: either one pixel arrives from SRAM or the whole block is
  // replaced by its permuted image in a single cycle.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_y][load_x] <= load_data;
    end else if (rot_en) begin
      mem <= rot_val;
    end
  end

  assign rd_data = mem[rd_y][rd_x];

endmodule

// File: rtl/diag_rotate_engine.sv
// ---------------------------------------------------------------------------
// diag_rotate_engine
// Walks an IMG_W x IMG_H frame in BLK x BLK blocks.  Each block is read
// from SRAM into a local buffer, given one key-selected diagonal rotation
// (or its inverse when decrypting) and written back in place.
// Ports:
//   Clk, Reset_N        clock, synchronous active-low reset
//   Run, decrypt        start request and direction, sampled in IDLE
//   subkey, key_ack     key word, taken in the cycle key_ack pulses
//   busy, done          busy outside IDLE, done pulses once per frame
//   SRAM_DQ_in/out/imp  SRAM data in, data out, 1 = DQ released (high-Z)
//   SRAM_ADDR           pixel address
//   SRAM_OE_N/WE_N      active-low output / write enables
//   blk_count           (only with DIAGROT_BLKCNT_EN) blocks finished in
//                       the current frame
// Build macro: DIAGROT_BLKCNT_EN adds the blk_count output and counter.
// ---------------------------------------------------------------------------
module diag_rotate_engine
  import diag_rot_pkg::*;
#(
  parameter int BLK    = 32,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int PIX_W  = 16,
  parameter int KEY_W  = 80,
  parameter int ADDR_W = 20
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              Run,
  input  logic              decrypt,
  input  logic [KEY_W-1:0]  subkey,
  output logic              key_ack,
  output logic              busy,
  output logic              done,
  input  logic [PIX_W-1:0]  SRAM_DQ_in,
  output logic [PIX_W-1:0]  SRAM_DQ_out,
  output logic              SRAM_DQ_imp,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
`ifdef DIAGROT_BLKCNT_EN
  ,
  output logic [15:0]       blk_count
`endif
);

  localparam int IW   = $clog2(BLK);
  localparam int KB_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  localparam logic [IW-1:0]   XY_LAST   = IW'(BLK - 1);
  localparam logic [15:0]     BX_LAST   = 16'(IMG_W / BLK - 1);
  localparam logic [15:0]     BY_LAST   = 16'(IMG_H / BLK - 1);
  localparam logic [KB_W-1:0] KBIT_LAST = KB_W'(KEY_W - 1);

  // Geometry guards: a partial block at the frame edge cannot be handled.
  if (BLK < 2 || (BLK & (BLK - 1)) != 0) begin : g_bad_blk
    $error("diag_rotate_engine: BLK must be a power of 2 and at least 2");
  end
  if (IMG_W % BLK != 0) begin : g_bad_w
    $error("diag_rotate_engine: IMG_W must be a multiple of BLK");
  end
  if (IMG_H % BLK != 0) begin : g_bad_h
    $error("diag_rotate_engine: IMG_H must be a multiple of BLK");
  end

  state_t          state;
  logic [IW-1:0]   x;
  logic [IW-1:0]   y;
  logic [15:0]     block_x;
  logic [15:0]     block_y;
  logic [KB_W-1:0] kbit;
  logic [KEY_W-1:0] key_reg;
  logic            dec_reg;
  logic            dir;
  logic            last_pix;
  logic [PIX_W-1:0] buf_rd;

  assign last_pix = (x == XY_LAST) && (y == XY_LAST);

  // Key bits are consumed MSB first, one per block.
  assign dir = key_reg[KBIT_LAST - kbit];

  diag_block_buf #(
    .BLK   (BLK),
    .PIX_W (PIX_W)
  ) u_buf (
    .clk       (Clk),
    .load_en   (state == ST_LOAD),
    .load_x    (x),
    .load_y    (y),
    .load_data (SRAM_DQ_in),
    .rd_x      (x),
    .rd_y      (y),
    .rd_data   (buf_rd),
    .rot_en    (state == ST_ROT),
    .dir       (dir),
    .inv       (dec_reg)
  );

  // Main sequencer.  x/y sweep each block in raster order during LOAD and
  // again during WRITE; because BLK is a power of two they wrap back to 0
  // on their own after the last pixel.  kbit only wraps after KEY_W blocks,
  // so key reloads follow the key width, not the frame geometry.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state   <= ST_IDLE;
      x       <= '0;
      y       <= '0;
      block_x <= '0;
      block_y <= '0;
      kbit    <= '0;
      key_reg <= '0;
      dec_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Run) begin
            dec_reg <= decrypt;
            block_x <= '0;
            block_y <= '0;
            kbit    <= '0;
            x       <= '0;
            y       <= '0;
            state   <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (kbit == '0) key_reg <= subkey;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          x <= x + 1'b1;
          if (x == XY_LAST) y <= y + 1'b1;
          if (last_pix) state <= ST_ROT;
        end
        ST_ROT: begin
          kbit  <= (kbit == KBIT_LAST) ? '0 : kbit + 1'b1;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          x <= x + 1'b1;
          if (x == XY_LAST) y <= y + 1'b1;
          if (last_pix) begin
            if (block_x == BX_LAST) begin
              block_x <= '0;
              if (block_y == BY_LAST) begin
                block_y <= '0;
                state   <= ST_DONE;
              end else begin
                block_y <= block_y + 1'b1;
                state   <= ST_KEY;
              end
            end else begin
              block_x <= block_x + 1'b1;
              state   <= ST_KEY;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // SRAM side and status outputs are decoded from the registered state so
  // that the asynchronous SRAM sees address and enables for a full cycle.
  always_comb begin
    key_ack     = 1'b0;
    done        = 1'b0;
    busy        = (state != ST_IDLE);
    SRAM_DQ_out = '0;
    SRAM_DQ_imp = 1'b1;
    SRAM_ADDR   = '0;
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    case (state)
      ST_KEY: begin
        key_ack = (kbit == '0);
      end
      ST_LOAD: begin
        SRAM_OE_N = 1'b0;
        SRAM_ADDR = ADDR_W'(pix_addr(32'(block_x), 32'(block_y), 32'(y), 32'(x), BLK, IMG_W));
      end
      ST_WRITE: begin
        SRAM_WE_N   = 1'b0;
        SRAM_DQ_imp = 1'b0;
        SRAM_DQ_out = buf_rd;
        SRAM_ADDR   = ADDR_W'(pix_addr(32'(block_x), 32'(block_y), 32'(y), 32'(x), BLK, IMG_W));
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef DIAGROT_BLKCNT_EN
  // Blocks finished in the current frame; holds after done so software can
  // read the final count, restarts when the next frame is accepted.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      blk_count <= '0;
    end else if (state == ST_IDLE && Run) begin
      blk_count <= '0;
    end else if (state == ST_WRITE && last_pix) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_diag_rotate_engine.sv
// ---------------------------------------------------------------------------
// tb_diag_rotate_engine
// Bench for diag_rotate_engine with BLK=4, an 8x8 frame (four blocks) and
// KEY_W=2, so the key is reloaded at blocks 0 and 2.  An SRAM model holds
// the frame; every write-back is matched against a queue of expected
// (address, data) pairs produced when each frame is started.  With
// DIAGROT_BLKCNT_EN defined the blk_count output is checked as well.
// ---------------------------------------------------------------------------
module tb_diag_rotate_engine;

  localparam int BLK       = 4;
  localparam int IMG_W     = 8;
  localparam int IMG_H     = 8;
  localparam int PIX_W     = 16;
  localparam int KEY_W     = 2;
  localparam int ADDR_W    = 20;
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int FRAME_LAT = 4 * (2 * BLK * BLK + 2) + 1;

  logic              Clk     = 1'b0;
  logic              Reset_N = 1'b0;
  logic              Run     = 1'b0;
  logic              decrypt = 1'b0;
  logic [KEY_W-1:0]  subkey  = '0;
  logic              key_ack;
  logic              busy;
  logic              done;
  logic [PIX_W-1:0]  dq_in;
  logic [PIX_W-1:0]  dq_out;
  logic              dq_imp;
  logic [ADDR_W-1:0] addr;
  logic              oe_n;
  logic              we_n;
`ifdef DIAGROT_BLKCNT_EN
  logic [15:0]       blk_count;
`endif

  logic [PIX_W-1:0] mem [NPIX];

  typedef struct {
    int               addr;
    logic [PIX_W-1:0] data;
  } sb_t;
  sb_t exp_q[$];

  typedef struct {
    logic [1:0]  key_a;
    logic [1:0]  key_b;
    logic        dec;
    int          addr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[16];

  int         n_total = 0;
  int         n_bad   = 0;
  int         cyc     = 0;
  int         acks    = 0;
  int         ack_cyc[4];
  logic       swap_pending = 1'b0;
  logic [1:0] key_b_pend   = '0;
  int         lat;

  always #5 Clk = ~Clk;

  // Asynchronous SRAM: read data follows the address while OE_N is low.
  assign dq_in = oe_n ? '0 : mem[addr[5:0]];

  diag_rotate_engine #(
    .BLK    (BLK),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_W  (PIX_W),
    .KEY_W  (KEY_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .Clk         (Clk),
    .Reset_N     (Reset_N),
    .Run         (Run),
    .decrypt     (decrypt),
    .subkey      (subkey),
    .key_ack     (key_ack),
    .busy        (busy),
    .done        (done),
    .SRAM_DQ_in  (dq_in),
    .SRAM_DQ_out (dq_out),
    .SRAM_DQ_imp (dq_imp),
    .SRAM_ADDR   (addr),
    .SRAM_OE_N   (oe_n),
    .SRAM_WE_N   (we_n)
`ifdef DIAGROT_BLKCNT_EN
    ,
    .blk_count   (blk_count)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Source pixel (r*4+c inside the block) of out[r][c], written straight
  // from the permutation tables; d mirrors columns on both sides.
  function automatic int src_idx(input int r, input int c, input logic d, input logic dec);
    int cc;
    int sr;
    int sc;
    cc = d ? 3 - c : c;
    if (!dec) begin
      if (r >= 1 && cc >= 1)      begin sr = r - 1;  sc = cc - 1; end
      else if (r == 0 && cc <= 2) begin sr = 3 - cc; sc = 3;      end
      else if (cc == 0)           begin sr = 3;      sc = 3 - r;  end
      else                        begin sr = 0;      sc = 3;      end
    end else begin
      if (r <= 2 && cc <= 2)      begin sr = r + 1;  sc = cc + 1; end
      else if (cc == 3 && r >= 1) begin sr = 0;      sc = 3 - r;  end
      else if (r == 3 && cc <= 2) begin sr = 3 - cc; sc = 0;      end
      else                        begin sr = 0;      sc = 3;      end
    end
    if (d) sc = 3 - sc;
    return sr * 4 + sc;
  endfunction

  // Queue the 64 writes of one frame from the current SRAM image.
  task automatic push_expected(input logic [1:0] key_a, input logic [1:0] key_b, input logic dec);
    for (int b = 0; b < 4; b++) begin
      int bx;
      int by;
      int base;
      logic [1:0] kreg;
      logic d;
      bx   = b % 2;
      by   = b / 2;
      base = by * BLK * IMG_W + bx * BLK;
      kreg = (b < 2) ? key_a : key_b;
      d    = kreg[1 - (b % 2)];
      for (int yy = 0; yy < BLK; yy++) begin
        for (int xx = 0; xx < BLK; xx++) begin
          sb_t e;
          int s;
          s      = src_idx(yy, xx, d, dec);
          e.addr = base + yy * IMG_W + xx;
          e.data = mem[base + (s / 4) * IMG_W + (s % 4)];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = PIX_W'(i);
  endtask

  // One clock: observe mid-cycle, commit SRAM writes, score them, and
  // swap the subkey one cycle after the first key_ack of a frame.
  task automatic tick();
    @(negedge Clk);
    cyc++;
    if (swap_pending) begin
      subkey       = key_b_pend;
      swap_pending = 1'b0;
    end
    if (key_ack) begin
      if (acks < 4) ack_cyc[acks] = cyc;
      acks++;
      if (acks == 1) swap_pending = 1'b1;
    end
    if (!we_n) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_write_addr", 32'(addr), 32'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        checkOutput("sb_addr", 32'(addr), 32'(e.addr));
        checkOutput("sb_data", 32'(dq_out), 32'(e.data));
      end
      mem[addr[5:0]] = dq_out;
    end
  endtask

  // Start a frame; returns after the accepting edge (cyc=1 is the KEY cycle).
  task automatic applyStimulus(input logic [1:0] key_a, input logic [1:0] key_b,
                               input logic dec, input logic hold);
    decrypt      = dec;
    subkey       = key_a;
    key_b_pend   = key_b;
    swap_pending = 1'b0;
    acks         = 0;
    cyc          = 0;
    for (int i = 0; i < 4; i++) ack_cyc[i] = -1;
    push_expected(key_a, key_b, dec);
    Run = 1'b1;
    tick();
    if (!hold) Run = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        l = cyc;
        break;
      end
      tick();
    end
    if (l < 0) begin
      n_total++;
      n_bad++;
      $display("[TB] FAIL done_timeout actual=no_done expected=done");
    end
  endtask

  initial begin
    int nd;

    vecs[0]  = '{2'b00, 2'b00, 1'b0,  0, 16'd27};
    vecs[1]  = '{2'b00, 2'b00, 1'b0,  9, 16'd0};
    vecs[2]  = '{2'b00, 2'b00, 1'b0,  3, 16'd3};
    vecs[3]  = '{2'b00, 2'b00, 1'b0,  8, 16'd26};
    vecs[4]  = '{2'b00, 2'b00, 1'b0, 36, 16'd63};
    vecs[5]  = '{2'b00, 2'b00, 1'b0, 54, 16'd45};
    vecs[6]  = '{2'b11, 2'b11, 1'b0,  3, 16'd24};
    vecs[7]  = '{2'b11, 2'b11, 1'b0, 10, 16'd3};
    vecs[8]  = '{2'b11, 2'b11, 1'b0, 16, 16'd9};
    vecs[9]  = '{2'b00, 2'b00, 1'b1,  0, 16'd9};
    vecs[10] = '{2'b00, 2'b00, 1'b1, 27, 16'd0};
    vecs[11] = '{2'b00, 2'b00, 1'b1, 19, 16'd1};
    vecs[12] = '{2'b01, 2'b01, 1'b0,  4, 16'd4};
    vecs[13] = '{2'b01, 2'b01, 1'b0, 39, 16'd60};
    vecs[14] = '{2'b00, 2'b11, 1'b0,  4, 16'd31};
    vecs[15] = '{2'b00, 2'b11, 1'b0, 32, 16'd32};

    // Reset values.
    init_mem();
    tick();
    tick();
    checkOutput("rst_busy",    32'(busy),    32'd0);
    checkOutput("rst_key_ack", 32'(key_ack), 32'd0);
    checkOutput("rst_done",    32'(done),    32'd0);
    checkOutput("rst_dq_imp",  32'(dq_imp),  32'd1);
    checkOutput("rst_oe_n",    32'(oe_n),    32'd1);
    checkOutput("rst_we_n",    32'(we_n),    32'd1);
    checkOutput("rst_addr",    32'(addr),    32'd0);
    checkOutput("rst_dq_out",  32'(dq_out),  32'd0);
    Reset_N = 1'b1;
    tick();

    // Table-driven frames with spot checks of the rotated image.
    for (int v = 0; v < 16; v++) begin
      init_mem();
      applyStimulus(vecs[v].key_a, vecs[v].key_b, vecs[v].dec, 1'b0);
`ifdef DIAGROT_BLKCNT_EN
      checkOutput("blk_count_start", 32'(blk_count), 32'd0);
`endif
      wait_done(lat);
      checkOutput("frame_latency", 32'(lat), 32'(FRAME_LAT));
      checkOutput("key_ack_count", 32'(acks), 32'd2);
      checkOutput("key_ack_blk0",  32'(ack_cyc[0]), 32'd1);
      checkOutput("key_ack_blk2",  32'(ack_cyc[1]), 32'(1 + 2 * (2 * BLK * BLK + 2)));
      checkOutput("busy_at_done",  32'(busy), 32'd1);
`ifdef DIAGROT_BLKCNT_EN
      checkOutput("blk_count_done", 32'(blk_count), 32'd4);
`endif
      checkOutput("sb_drained",    32'(exp_q.size()), 32'd0);
      checkOutput($sformatf("pixel_vec%0d", v), 32'(mem[vecs[v].addr]), 32'(vecs[v].exp));
      tick();
`ifdef DIAGROT_BLKCNT_EN
      checkOutput("blk_count_hold", 32'(blk_count), 32'd4);
`endif
    end

    // Encrypt then decrypt with the same key restores the frame.
    for (int k = 0; k < 4; k++) begin
      init_mem();
      applyStimulus(2'(k), 2'(k), 1'b0, 1'b0);
      wait_done(lat);
      tick();
      applyStimulus(2'(k), 2'(k), 1'b1, 1'b0);
      wait_done(lat);
      tick();
      nd = 0;
      for (int i = 0; i < NPIX; i++) if (mem[i] !== PIX_W'(i)) nd++;
      checkOutput($sformatf("roundtrip_key%0d_diffs", k), 32'(nd), 32'd0);
    end

    // Reset during LOAD of block 1, then a clean restart.
    init_mem();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    while (cyc < 40) tick();
    checkOutput("midload_oe_n", 32'(oe_n), 32'd0);
    Reset_N = 1'b0;
    tick();
    checkOutput("midrst_busy",   32'(busy),   32'd0);
    checkOutput("midrst_we_n",   32'(we_n),   32'd1);
    checkOutput("midrst_oe_n",   32'(oe_n),   32'd1);
    checkOutput("midrst_dq_imp", 32'(dq_imp), 32'd1);
    checkOutput("midrst_addr",   32'(addr),   32'd0);
    Reset_N = 1'b1;
    exp_q.delete();
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("restart_key_ack", 32'(key_ack), 32'd1);
    tick();
    checkOutput("restart_addr", 32'(addr), 32'd0);
    checkOutput("restart_oe_n", 32'(oe_n), 32'd0);
    wait_done(lat);
    checkOutput("restart_latency", 32'(lat), 32'(FRAME_LAT));
    tick();

    // Run held high: ignored while busy, next frame one cycle after done.
    init_mem();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
    wait_done(lat);
    checkOutput("held_latency", 32'(lat), 32'(FRAME_LAT));
    checkOutput("held_acks", 32'(acks), 32'd2);
    tick();
    checkOutput("held_idle_busy", 32'(busy), 32'd0);
    checkOutput("held_idle_ack",  32'(key_ack), 32'd0);
    push_expected(2'b00, 2'b00, 1'b0);
    tick();
    checkOutput("held_restart_ack",  32'(key_ack), 32'd1);
    checkOutput("held_restart_busy", 32'(busy), 32'd1);
    Run = 1'b0;
    wait_done(lat);
    checkOutput("held_second_done", 32'(lat), 32'(2 * FRAME_LAT + 1));
    tick();
    checkOutput("held_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
